// File: rtl/main_mem_responder.sv
// main_mem_responder: answers cache line refill/writeback bursts from a word-addressed memory after a fixed latency.
// Define MEM_STATS_EN to add saturating read-line, write-line and busy-cycle counters.
module main_mem_responder #(
  parameter int LINE_ADDR_LEN = 3,
  parameter int MEM_ADDR_LEN  = 10,
  parameter int LATENCY       = 4
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  req_valid,
  output logic                                  req_ready,
  input  logic                                  req_we,
  input  logic [MEM_ADDR_LEN-LINE_ADDR_LEN-1:0] req_line_addr,
  output logic                                  rd_valid,
  output logic [31:0]                           rd_data,
  output logic [LINE_ADDR_LEN-1:0]              rd_idx,
  output logic                                  wr_ready,
  input  logic                                  wr_valid,
  input  logic [31:0]                           wr_data,
  output logic                                  done
`ifdef MEM_STATS_EN
  ,
  output logic [31:0]                           rd_line_count,
  output logic [31:0]                           wr_line_count,
  output logic [31:0]                           busy_cycles
`endif
);
  localparam int CW = $clog2(LATENCY + 1);
  typedef enum logic [2:0] {IDLE, WAIT, READ, WRITE, DONE} state_e;
  state_e                                state_q, state_d;
  logic [CW-1:0]                         cnt_q;
  logic [LINE_ADDR_LEN-1:0]              idx_q, rd_idx_q;
  logic [MEM_ADDR_LEN-LINE_ADDR_LEN-1:0] line_q;
  logic                                  we_q, rd_valid_q, wr_ready_q, done_q;
  logic [31:0]                           rd_data_q;
  logic [31:0]                           mem_q [1<<MEM_ADDR_LEN];
  logic                                  last_wait, rd_emit, wr_take, fin, wr_open;
  always_comb begin
    last_wait = state_q == WAIT && cnt_q == CW'(1);
    rd_emit   = (last_wait && !we_q) || (state_q == READ && rd_idx_q != '1);
    wr_take   = state_q == WRITE && wr_valid;
    fin       = (state_q == READ && rd_idx_q == '1) || (wr_take && idx_q == '1);
    wr_open   = (last_wait && we_q) || (state_q == WRITE && !fin);
    state_d   = state_q == IDLE ? (req_valid ? WAIT : IDLE) :
                last_wait       ? (we_q ? WRITE : READ) :
                fin             ? DONE :
                state_q == DONE ? IDLE : state_q;
  end
  // idx_q always wraps back to 0 at the end of a burst, so WAIT starts every burst at word 0
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      we_q       <= 1'b0;
      line_q     <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      rd_idx_q   <= '0;
      wr_ready_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rd_valid_q <= rd_emit;
      wr_ready_q <= wr_open;
      done_q     <= fin;
      if (state_q == IDLE) cnt_q <= CW'(LATENCY);
      else if (state_q == WAIT) cnt_q <= cnt_q - 1'b1;
      if (state_q == IDLE && req_valid) begin
        we_q   <= req_we;
        line_q <= req_line_addr;
      end
      if (rd_emit) begin
        rd_data_q <= mem_q[{line_q, idx_q}];
        rd_idx_q  <= idx_q;
      end
      if (rd_emit || wr_take) idx_q <= idx_q + 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst && wr_take) mem_q[{line_q, idx_q}] <= wr_data;
  end
  assign req_ready = state_q == IDLE && !rst;
  assign rd_valid  = rd_valid_q;
  assign rd_data   = rd_data_q;
  assign rd_idx    = rd_idx_q;
  assign wr_ready  = wr_ready_q;
  assign done      = done_q;
`ifdef MEM_STATS_EN
  logic [31:0] rd_cnt_q, wr_cnt_q, busy_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
      busy_q   <= '0;
    end else begin
      if (state_q == DONE && !we_q && rd_cnt_q != '1) rd_cnt_q <= rd_cnt_q + 1'b1;
      if (state_q == DONE && we_q && wr_cnt_q != '1) wr_cnt_q <= wr_cnt_q + 1'b1;
      if (state_q != IDLE && busy_q != '1) busy_q <= busy_q + 1'b1;
    end
  end
  assign rd_line_count = rd_cnt_q;
  assign wr_line_count = wr_cnt_q;
  assign busy_cycles   = busy_q;
`endif
endmodule

// File: tb/tb_main_mem_responder.sv
// tb_main_mem_responder: directed checks of reset, refill latency, stalled writeback, wrap, abort and busy rejection.
module tb_main_mem_responder;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [6:0]  req_line_addr = '0;
  logic        rd_valid;
  logic [31:0] rd_data;
  logic [2:0]  rd_idx;
  logic        wr_ready;
  logic        wr_valid = 1'b0;
  logic [31:0] wr_data = '0;
  logic        done;
`ifdef MEM_STATS_EN
  logic [31:0] rd_line_count, wr_line_count, busy_cycles;
`endif
  int          npass = 0;
  int          nfail = 0;
  int          ntot = 0;
  int          ndone = 0;
  logic [31:0] got [8];

  main_mem_responder dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_line_addr(req_line_addr), .rd_valid(rd_valid), .rd_data(rd_data), .rd_idx(rd_idx),
    .wr_ready(wr_ready), .wr_valid(wr_valid), .wr_data(wr_data), .done(done)
`ifdef MEM_STATS_EN
    , .rd_line_count(rd_line_count), .wr_line_count(wr_line_count), .busy_cycles(busy_cycles)
`endif
  );

  always #5 clk = ~clk;
  always @(negedge clk) if (done) ndone++;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic read_line(input logic [6:0] line, input logic pulse);
    int lat;
    req_valid = 1'b1; req_we = 1'b0; req_line_addr = line;
    step();
    req_valid = pulse;
    step();
    req_valid = 1'b0;
    lat = 1;
    while (!rd_valid && lat < 40) begin step(); lat++; end
    chk("rd_latency", lat, 4);
    for (int k = 0; k < 8; k++) begin
      chk("rd_valid", {31'd0, rd_valid}, 1);
      chk("rd_idx", {29'd0, rd_idx}, k);
      got[k] = rd_data;
      step();
    end
    chk("rd_valid_drop", {31'd0, rd_valid}, 0);
    chk("rd_done", {31'd0, done}, 1);
    chk("rd_ready_in_done", {31'd0, req_ready}, 0);
    step();
    chk("rd_done_pulse", {31'd0, done}, 0);
    chk("rd_ready_back", {31'd0, req_ready}, 1);
  endtask

  task automatic write_line(input logic [6:0] line, input logic [31:0] base, input logic stall, input int n);
    int t;
    req_valid = 1'b1; req_we = 1'b1; req_line_addr = line;
    step();
    req_valid = 1'b0; req_we = 1'b0;
    t = 0;
    while (!wr_ready && t < 40) begin step(); t++; end
    chk("wr_latency", t, 4);
    for (int k = 0; k < n; k++) begin
      wr_valid = 1'b1; wr_data = base + k;
      step();
      if (k < 7) chk("wr_open", {30'd0, wr_ready, done}, 32'h2);
      if (stall && k == 3) begin
        wr_valid = 1'b0;
        repeat (3) begin step(); chk("wr_stall", {30'd0, wr_ready, done}, 32'h2); end
      end
    end
    wr_valid = 1'b0;
    if (n == 8) begin
      chk("wr_done", {30'd0, wr_ready, done}, 32'h1);
      step();
      chk("wr_ready_back", {30'd0, req_ready, done}, 32'h2);
    end
  endtask

  initial begin
    int d0;
`ifdef MEM_STATS_EN
    logic [31:0] rc, wc, bc;
`endif
    repeat (3) begin
      step();
      chk("reset_outputs", {req_ready, rd_valid, wr_ready, done, rd_idx, rd_data[24:0]}, 0);
      chk("reset_rd_data", rd_data, 0);
    end
    rst = 1'b0;
    step();
    chk("post_reset_ready", {31'd0, req_ready}, 1);
    repeat (4) step();
    chk("idle_no_done", ndone, 0);
`ifdef MEM_STATS_EN
    chk("stats_reset", rd_line_count | wr_line_count | busy_cycles, 0);
`endif
    for (int l = 0; l < 128; l++) write_line(7'(l), 32'h100 + 32'(l) * 8, 1'b0, 8);
    d0 = ndone;
    read_line(7'd5, 1'b1);
    for (int k = 0; k < 8; k++) chk("line5_data", got[k], 32'h128 + k);
    repeat (5) step();
    chk("busy_single_done", ndone - d0, 1);
    chk("busy_no_extra", {30'd0, rd_valid, req_ready}, 32'h1);
    write_line(7'd2, 32'hA0, 1'b1, 8);
    read_line(7'd2, 1'b0);
    for (int k = 0; k < 8; k++) chk("line2_readback", got[k], 32'hA0 + k);
    read_line(7'd127, 1'b0);
    for (int k = 0; k < 8; k++) chk("line127_wrap", got[k], 32'h4F8 + k);
    read_line(7'd0, 1'b0);
    for (int k = 0; k < 8; k++) chk("line0_intact", got[k], 32'h100 + k);
    d0 = ndone;
    write_line(7'd9, 32'hB0, 1'b0, 3);
    rst = 1'b1;
    step();
    chk("abort_ready_low", {31'd0, req_ready}, 0);
    step();
    rst = 1'b0;
    step();
    chk("abort_idle", {29'd0, req_ready, wr_ready, done}, 32'h4);
    chk("abort_no_done", ndone - d0, 0);
    read_line(7'd9, 1'b0);
    for (int k = 0; k < 3; k++) chk("line9_new", got[k], 32'hB0 + k);
    for (int k = 3; k < 8; k++) chk("line9_old", got[k], 32'h148 + k);
`ifdef MEM_STATS_EN
    rc = rd_line_count; wc = wr_line_count; bc = busy_cycles;
    read_line(7'd3, 1'b0);
    write_line(7'd3, 32'hC0, 1'b0, 8);
    chk("stats_rd", rd_line_count - rc, 1);
    chk("stats_wr", wr_line_count - wc, 1);
    chk("stats_busy", busy_cycles - bc, 26);
`endif
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
